config_chain_loader: RTL
========================

// Module: config_chain_loader
// PURPOSE
//  Sequences the serial configuration chain feeding the tile's config_in buses, including the multiplexer selector bits.
//  Accepts a bitstream word-by-word over a valid/ready handshake and serialises it LSB-first onto config_out.
//  Drives config_enable so that exactly CHAIN_LENGTH bits are shifted, then reports done.
//  Sits between the bitstream source (host/flash reader) and the tile config shift chain.
// PARAMETERS
//  CHAIN_LENGTH  20  total config bits in the chain (e.g. 4 muxes x 5 selector bits); >= 1
//  WORD_WIDTH    8   bitstream word width; >= 1. Words needed = ceil(CHAIN_LENGTH/WORD_WIDTH)
// PORTS
//  clock            in   1           single clock for all logic and the chain
//  reset            in   1           asynchronous, active-high reset
//  start            in   1           pulse: begin a load; ignored while busy=1
//  abort            in   1           pulse: cancel the load in progress
//  bitstream_data   in   WORD_WIDTH  next bitstream word; bit 0 is shifted first
//  bitstream_valid  in   1           bitstream_data is valid
//  bitstream_ready  out  1           loader accepts a word this cycle
//  config_out       out  1           serial bit into the chain head
//  config_enable    out  1           chain shift enable; the chain shifts on each clock with enable=1
//  busy             out  1           high in LOAD/SHIFT
//  done             out  1           high from load completion until next start/abort/reset
//  checksum         out  8           CRC-8 of the shifted bits (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async): state=IDLE, bitstream_ready=0, config_out=0, config_enable=0, busy=0, done=0, checksum=0, counters=0.
//  FSM states: IDLE, LOAD (word buffer empty, waiting), SHIFT (emitting bits), DONE.
//   IDLE  --start--> LOAD; clears the bit counter and checksum.
//   LOAD  --valid&ready--> SHIFT; bitstream_ready=1 for the whole of LOAD.
//   SHIFT: one bit per cycle, config_enable=1, config_out=buffer[bit_idx].
//          Last bit of the word with more chain bits still needed: bitstream_ready=1.
//           If a word is accepted, SHIFT continues with the new word's bit 0 next cycle (no bubble).
//           Otherwise -> LOAD (underrun: config_enable=0, chain holds its state).
//          The bit that makes total == CHAIN_LENGTH -> DONE. Remaining bits of a partial final word are discarded.
//   DONE: done=1, busy=0, config_enable=0; --start--> LOAD (done clears the same cycle).
//  Latency: word accepted in cycle N -> its bit 0 appears on config_out with config_enable=1 in cycle N+1.
//  Total words accepted per load = ceil(CHAIN_LENGTH/WORD_WIDTH); bitstream_ready is never high once the final word is taken.
//  bit counter width = clog2(CHAIN_LENGTH+1); it never wraps and saturates at CHAIN_LENGTH.
//  abort in LOAD/SHIFT: next cycle state=IDLE, config_enable=0, bitstream_ready=0, done=0; the chain holds its partial contents.
//  abort has priority over a same-cycle handshake; the word is not consumed.
//  abort in IDLE or DONE: returns to IDLE and clears done.
//  start with abort in the same cycle: abort wins.
//  start while busy: ignored.
//  All outputs are registered.
// CONFIGURATION
//  Macro CONFIG_CHAIN_CHECKSUM_EN:
//   defined: checksum = CRC-8 (poly 0x07, init 0x00, bit-serial, no reflection) over every bit shifted with config_enable=1.
//    Cleared on start; holds its value in DONE and after abort.
//   undefined: checksum is tied to 8'h00 and no CRC logic is built; the port list is unchanged.
// TESTING
//  1. CHAIN_LENGTH=20, WORD_WIDTH=8; words 0xA5,0x3C,0x0F back-to-back -> 20 contiguous enable cycles, bits LSB-first;
//     bits 4-7 of 0x0F dropped; done=1 on the cycle after the 20th bit; exactly 3 handshakes.
//  2. Source withholds valid for 5 cycles after word 1 -> config_enable=0 for those cycles, no bits lost or duplicated; total enables=20.
//  3. abort asserted after 9 bits -> IDLE next cycle, enable=0, done=0.
//     A new start reloads all 20 bits, with checksum restarted at 0.
//  4. start pulsed in SHIFT -> ignored; start with abort in the same cycle -> IDLE.
//  5. reset asserted mid-SHIFT, asynchronously -> all outputs 0 immediately, without waiting for a clock edge.
//  6. With CONFIG_CHAIN_CHECKSUM_EN, CHAIN_LENGTH=8, word 0x01 -> checksum matches the golden bit-serial CRC-8 model;
//     without the macro, checksum=8'h00.

Source files
------------

// File: rtl/config_chain_loader.sv
// config_chain_loader: feeds the tile's serial configuration chain (including mux
// selector bits) from a word-wide bitstream source. Words arrive over valid/ready,
// are serialised LSB-first onto config_out, and config_enable is asserted for
// exactly CHAIN_LENGTH shift cycles before the loader reports done.
//
// Optional feature: define CONFIG_CHAIN_CHECKSUM_EN to build a bit-serial CRC-8
// (poly 0x07, init 0x00, no reflection) over every bit shifted into the chain.
// Without the macro, checksum is tied to zero and no CRC logic exists.
`timescale 1ns/1ps

module config_chain_loader #(
    parameter int unsigned CHAIN_LENGTH = 20,
    parameter int unsigned WORD_WIDTH   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] bitstream_data,
    input  logic                  bitstream_valid,
    output logic                  bitstream_ready,
    output logic                  config_out,
    output logic                  config_enable,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            checksum
);

    localparam int unsigned CntW = $clog2(CHAIN_LENGTH + 1);
    localparam int unsigned IdxW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    localparam logic [CntW-1:0] CntMax  = CntW'(CHAIN_LENGTH);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(WORD_WIDTH - 1);
    localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [WORD_WIDTH-1:0] buf_q, buf_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [CntW-1:0]       cnt_inc;

    // Registered output copies; every port is driven straight from a flop.
    logic ready_q, ready_d;
    logic out_q, out_d;
    logic enable_q, enable_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    // Bits fully shifted once the current SHIFT cycle completes; saturates at the chain length.
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;

    // Next-state logic: abort always wins, including over a same-cycle handshake.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle, StDone: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (start) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            StLoad: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (bitstream_valid && ready_q) begin
                    buf_d   = bitstream_data;
                    idx_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CntMax) begin
                        // Any unused upper bits of a partial final word are dropped here.
                        state_d = StDone;
                    end else if (idx_q == IdxLast) begin
                        if (bitstream_valid && ready_q) begin
                            // Back-to-back word: next cycle carries its bit 0, no bubble.
                            buf_d = bitstream_data;
                            idx_d = '0;
                        end else begin
                            // Underrun: stop shifting and wait for the source.
                            state_d = StLoad;
                        end
                    end else begin
                        idx_d = idx_q + IdxOne;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode from the next state so the registered outputs line up with it.
    always_comb begin
        enable_d = (state_d == StShift);
        busy_d   = (state_d == StLoad) || (state_d == StShift);
        done_d   = (state_d == StDone);
        // In SHIFT, ready only on a word's last bit and only if the chain still needs
        // bits beyond it, so ready never rises once the final word has been taken.
        ready_d  = (state_d == StLoad) ||
                   ((state_d == StShift) && (idx_d == IdxLast) && (cnt_d < CntMax - CntOne));
        out_d    = enable_d ? buf_d[idx_d] : out_q;
    end

    // State, datapath and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            buf_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            out_q    <= 1'b0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            out_q    <= out_d;
            enable_q <= enable_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bitstream_ready = ready_q;
    assign config_out      = out_q;
    assign config_enable   = enable_q;
    assign busy            = busy_q;
    assign done            = done_q;

`ifdef CONFIG_CHAIN_CHECKSUM_EN
    logic       crc_restart;
    logic [7:0] crc_q, crc_d;

    // A load begins whenever an idle/done loader takes start without abort.
    assign crc_restart = ((state_q == StIdle) || (state_q == StDone)) && start && !abort;

    // Fold in the bit the chain shifts this cycle; holds otherwise (DONE, after abort).
    always_comb begin
        crc_d = crc_q;
        if (crc_restart) begin
            crc_d = 8'h00;
        end else if (enable_q) begin
            crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ out_q) ? 8'h07 : 8'h00);
        end
    end

    // CRC register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign checksum = crc_q;
`else
    assign checksum = 8'h00;
`endif

endmodule
